dmem_copy_engine: RTL and testbench

Bus-initiator block that copies a block of words within data memory using the processor's single data-memory port (address, write enable, write data, registered read data). It sits beside the pipeline in the I/O system; the top level muxes its port outputs onto the data memory while `busy` is high. The block moves one word per two cycles and range-checks the source and destination before any access.

---
 rtl/dmem_copy_pkg.sv | 17 +
 rtl/dmem_range_check.sv | 31 +++
 rtl/dmem_copy_engine.sv | 134 +++++++++++++
 tb/tb_dmem_copy_engine.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_copy_pkg.sv
// Shared types and constants for the data-memory copy engine.
package dmem_copy_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } copy_state_t;

  localparam int WORD_BYTES = 4;

  function automatic logic [32:0] region_bytes(input int data_brams);
    return 33'd1 << (11 + data_brams);
  endfunction

endpackage

// File: rtl/dmem_range_check.sv
// Combinational legality check for one copy endpoint: word alignment, region
// membership, and that the whole block of words ends inside the region.
module dmem_range_check
  import dmem_copy_pkg::*;
#(
  parameter int          DATA_BRAMS         = 1,
  parameter logic [31:0] DATA_START_ADDRESS = 32'h00800000,
  parameter int          COUNT_BITS         = 16
) (
  input  logic [31:0]           base_addr,
  input  logic [COUNT_BITS-1:0] count,
  output logic                  ok
);

  localparam logic [32:0] REGION_START = {1'b0, DATA_START_ADDRESS};
  localparam logic [32:0] REGION_END   = REGION_START + region_bytes(DATA_BRAMS);

  logic [32:0] addr_ext;
  logic [32:0] end_addr;

  // The end bound is formed at 33 bits so an address near 2^32 cannot wrap and pass.
  always_comb begin
    addr_ext = {1'b0, base_addr};
    end_addr = addr_ext + (33'(count) * 33'(WORD_BYTES));
    ok = (base_addr[1:0] == 2'b00) &&
         (addr_ext >= REGION_START) &&
         (addr_ext < REGION_END) &&
         (end_addr <= REGION_END);
  end

endmodule

// File: rtl/dmem_copy_engine.sv
// Block copy engine that drives the shared data-memory port: one word per
// READ/WRITE pair, with both endpoints range-checked before any access.
module dmem_copy_engine
  import dmem_copy_pkg::*;
#(
  parameter int          DATA_BRAMS         = 1,
  parameter logic [31:0] DATA_START_ADDRESS = 32'h00800000,
  parameter int          COUNT_BITS         = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [31:0]           src_addr,
  input  logic [31:0]           dst_addr,
  input  logic [COUNT_BITS-1:0] word_count,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [COUNT_BITS-1:0] words_done,
  output logic [31:0]           dAddress,
  output logic                  MemWrite,
  output logic [31:0]           dWriteData,
  input  logic [31:0]           dReadData
);

  localparam logic [COUNT_BITS-1:0] ONE = 1;

  copy_state_t           state_q, state_d;
  logic [31:0]           src_q, src_d;
  logic [31:0]           dst_q, dst_d;
  logic [COUNT_BITS-1:0] count_q, count_d;
  logic [COUNT_BITS-1:0] words_done_q, words_done_d;
  logic                  error_q, error_d;
  logic                  src_ok, dst_ok;

  dmem_range_check #(
    .DATA_BRAMS        (DATA_BRAMS),
    .DATA_START_ADDRESS(DATA_START_ADDRESS),
    .COUNT_BITS        (COUNT_BITS)
  ) u_src_check (
    .base_addr(src_addr),
    .count    (word_count),
    .ok       (src_ok)
  );

  dmem_range_check #(
    .DATA_BRAMS        (DATA_BRAMS),
    .DATA_START_ADDRESS(DATA_START_ADDRESS),
    .COUNT_BITS        (COUNT_BITS)
  ) u_dst_check (
    .base_addr(dst_addr),
    .count    (word_count),
    .ok       (dst_ok)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      count_q      <= '0;
      words_done_q <= '0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      count_q      <= count_d;
      words_done_q <= words_done_d;
      error_q      <= error_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    count_d      = count_q;
    words_done_d = words_done_q;
    error_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (src_ok && dst_ok) begin
            src_d        = src_addr;
            dst_d        = dst_addr;
            count_d      = word_count;
            words_done_d = '0;
            state_d      = (word_count == '0) ? DONE : READ;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      // Aborting here drops the word whose read is in flight.
      READ:    state_d = abort ? DONE : WRITE;
      WRITE: begin
        src_d        = src_q + 32'(WORD_BYTES);
        dst_d        = dst_q + 32'(WORD_BYTES);
        words_done_d = words_done_q + ONE;
        state_d      = ((words_done_d == count_q) || abort) ? DONE : READ;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    MemWrite   = 1'b0;
    dAddress   = '0;
    dWriteData = '0;
    case (state_q)
      READ: begin
        busy     = 1'b1;
        dAddress = src_q;
      end
      WRITE: begin
        busy       = 1'b1;
        MemWrite   = 1'b1;
        dAddress   = dst_q;
        dWriteData = dReadData;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign error      = error_q;
  assign words_done = words_done_q;

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Directed bench for dmem_copy_engine: a registered-read memory plus a
// word-level copy model that predicts every port value cycle by cycle.
module tb_dmem_copy_engine;

  localparam logic [31:0] BASE = 32'h00800000;
  localparam int          WORDS = 1024;

  logic        clk, rst, start, abort;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] word_count;
  logic        busy, done, error, MemWrite;
  logic [15:0] words_done;
  logic [31:0] dAddress, dWriteData, dReadData;

  logic [31:0] mem    [0:WORDS-1];
  logic [31:0] refMem [0:WORDS-1];
  logic        loadEn;
  logic [9:0]  loadIdx;
  logic [31:0] loadData;
  int          badWrites;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] prevWD;
  int          lastDone, lastErr, lastBusy, lastWr;

  dmem_copy_engine dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .word_count(word_count),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .words_done(words_done),
    .dAddress  (dAddress),
    .MemWrite  (MemWrite),
    .dWriteData(dWriteData),
    .dReadData (dReadData)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Data memory with registered read; preloaded through loadEn while the engine is held in reset.
  initial badWrites = 0;
  always @(posedge clk) begin
    if (loadEn) begin
      mem[loadIdx] <= loadData;
    end else if (MemWrite) begin
      if (dAddress[31:12] == BASE[31:12]) mem[dAddress[11:2]] <= dWriteData;
      else badWrites <= badWrites + 1;
    end
    dReadData <= mem[dAddress[11:2]];
  end

  function automatic logic [31:0] initVal(input int i);
    if (i < 4) return 32'h11111111 * (i + 1);
    return 32'hA5000000 | 32'(i);
  endfunction

  function automatic int wordIdx(input logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  function automatic bit legalReq(input logic [31:0] a, input int cnt);
    longint av, regionEnd;
    av = longint'(a);
    regionEnd = longint'(BASE) + 4096;
    return (a[1:0] == 2'b00) && (av >= longint'(BASE)) && (av < regionEnd) &&
           (av + 4 * longint'(cnt) <= regionEnd);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Runs one request and checks every port on every cycle against the copy model.
  task automatic applyStimulus(input logic [31:0] s, input logic [31:0] d, input int n,
                               input int abortAt, input int restartAt, input int resetAt);
    logic [31:0] tmp [0:WORDS-1];
    logic [31:0] expData [0:63];
    bit          accept, inFlight;
    int          planD, planN, committed, mismatches;
    logic        eBusy, eDone, eErr, eMW;
    logic [31:0] eAddr, eWData;
    logic [15:0] eWD;

    accept = legalReq(s, n) && legalReq(d, n);
    if (!accept) begin
      planD = 0; planN = 0;
    end else if (n == 0) begin
      planD = 1; planN = 0;
    end else if (abortAt >= 1 && abortAt <= 2 * n) begin
      planD = abortAt + 1; planN = abortAt / 2;
    end else begin
      planD = 2 * n + 1; planN = n;
    end
    committed = (resetAt > 0) ? (resetAt - 1) / 2 : planN;
    for (int i = 0; i < WORDS; i++) tmp[i] = refMem[i];
    for (int j = 0; j < planN; j++) begin
      expData[j] = tmp[wordIdx(s) + j];
      tmp[wordIdx(d) + j] = expData[j];
      if (j < committed) refMem[wordIdx(d) + j] = expData[j];
    end

    @(negedge clk); #1;
    src_addr = s; dst_addr = d; word_count = 16'(n); start = 1'b1;
    lastBusy = 0; lastDone = 0; lastErr = 0; lastWr = 0;
    for (int k = 1; k <= 2 * n + 4; k++) begin
      @(negedge clk);
      if (!accept) begin
        eBusy = 0; eDone = 0; eErr = (k == 1); eMW = 0; eAddr = '0; eWData = '0; eWD = prevWD;
      end else begin
        inFlight = (k < planD);
        eBusy  = inFlight;
        eDone  = (k == planD);
        eErr   = 0;
        eMW    = inFlight && (k % 2 == 0);
        eAddr  = !inFlight ? 32'h0 : eMW ? d + 32'(4 * (k / 2 - 1)) : s + 32'(4 * ((k - 1) / 2));
        eWData = eMW ? expData[k / 2 - 1] : 32'h0;
        eWD    = 16'((((k - 1) / 2) < planN) ? (k - 1) / 2 : planN);
      end
      checkOutput("busy", 32'(busy), 32'(eBusy));
      checkOutput("done", 32'(done), 32'(eDone));
      checkOutput("error", 32'(error), 32'(eErr));
      checkOutput("MemWrite", 32'(MemWrite), 32'(eMW));
      checkOutput("dAddress", dAddress, eAddr);
      checkOutput("dWriteData", dWriteData, eWData);
      checkOutput("words_done", 32'(words_done), 32'(eWD));
      lastBusy += int'(busy);
      lastWr   += int'(MemWrite);
      if (done && lastDone == 0) lastDone = k;
      if (error && lastErr == 0) lastErr = k;
      #1;
      start = (k == restartAt);
      if (k == restartAt) src_addr = BASE + 32'h2;
      abort = (k == abortAt);
      if (k == resetAt) begin
        rst = 1'b1;
        #1;
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_MemWrite", 32'(MemWrite), 32'h0);
        checkOutput("reset_words_done", 32'(words_done), 32'h0);
        break;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    if (resetAt > 0) begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      prevWD = '0;
    end else begin
      checkOutput("done_cycle", 32'(lastDone), 32'(accept ? planD : 0));
      checkOutput("error_cycle", 32'(lastErr), 32'(accept ? 0 : 1));
      checkOutput("busy_cycles", 32'(lastBusy), 32'(accept ? planD - 1 : 0));
      checkOutput("write_count", 32'(lastWr), 32'(planN));
      if (accept) prevWD = 16'(planN);
    end
    mismatches = 0;
    for (int i = 0; i < WORDS; i++) if (mem[i] !== refMem[i]) mismatches++;
    checkOutput("mem_image", 32'(mismatches), 32'h0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; loadEn = 1'b0;
    src_addr = '0; dst_addr = '0; word_count = '0; loadIdx = '0; loadData = '0;
    prevWD = '0;
    #3;
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_done", 32'(done), 32'h0);
    checkOutput("rst_error", 32'(error), 32'h0);
    checkOutput("rst_MemWrite", 32'(MemWrite), 32'h0);
    checkOutput("rst_dAddress", dAddress, 32'h0);
    checkOutput("rst_dWriteData", dWriteData, 32'h0);
    checkOutput("rst_words_done", 32'(words_done), 32'h0);

    for (int i = 0; i < WORDS; i++) begin
      @(negedge clk);
      loadEn = 1'b1; loadIdx = 10'(i); loadData = initVal(i);
      refMem[i] = initVal(i);
    end
    @(negedge clk);
    loadEn = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(BASE, BASE + 32'h100, 4, 0, 0, 0);
    checkOutput("t1_done_cycle", 32'(lastDone), 32'd9);
    checkOutput("t1_busy_cycles", 32'(lastBusy), 32'd8);
    checkOutput("t1_words_done", 32'(words_done), 32'd4);
    checkOutput("t1_dst0", mem[64], 32'h11111111);
    checkOutput("t1_dst1", mem[65], 32'h22222222);
    checkOutput("t1_dst2", mem[66], 32'h33333333);
    checkOutput("t1_dst3", mem[67], 32'h44444444);

    applyStimulus(BASE, BASE + 32'h200, 0, 0, 0, 0);
    checkOutput("t2_done_cycle", 32'(lastDone), 32'd1);
    checkOutput("t2_busy_cycles", 32'(lastBusy), 32'd0);
    checkOutput("t2_writes", 32'(lastWr), 32'd0);

    applyStimulus(BASE + 32'h2, BASE + 32'h200, 1, 0, 0, 0);
    checkOutput("t3_error_cycle", 32'(lastErr), 32'd1);
    checkOutput("t3_busy_cycles", 32'(lastBusy), 32'd0);

    applyStimulus(BASE, 32'h00400000, 1, 0, 0, 0);
    checkOutput("t4_error_cycle", 32'(lastErr), 32'd1);

    applyStimulus(BASE + 32'hFFC, BASE + 32'h300, 2, 0, 0, 0);
    checkOutput("t5_end_error", 32'(lastErr), 32'd1);
    applyStimulus(BASE + 32'hFFC, BASE + 32'h300, 1, 0, 0, 0);
    checkOutput("t5_end_ok_done", 32'(lastDone), 32'd3);
    checkOutput("t5_end_ok_word", mem[192], 32'hA50003FF);

    applyStimulus(BASE + 32'h10, BASE + 32'h400, 5, 4, 0, 0);
    checkOutput("t6_abort_done", 32'(lastDone), 32'd5);
    checkOutput("t6_abort_words", 32'(words_done), 32'd2);
    checkOutput("t6_abort_word0", mem[256], 32'hA5000004);
    checkOutput("t6_abort_word2", mem[258], 32'hA5000102);

    applyStimulus(BASE, BASE + 32'h600, 3, 3, 0, 0);
    checkOutput("t7_rdabort_done", 32'(lastDone), 32'd4);
    checkOutput("t7_rdabort_words", 32'(words_done), 32'd1);

    applyStimulus(BASE, BASE + 32'h700, 2, 0, 2, 0);
    checkOutput("t8_busy_start_err", 32'(lastErr), 32'd0);

    applyStimulus(BASE, BASE + 32'h500, 4, 0, 0, 4);
    checkOutput("t9_reset_word0", mem[320], 32'h11111111);
    checkOutput("t9_reset_word1", mem[321], 32'hA5000141);

    applyStimulus(BASE + 32'h20, BASE + 32'h500, 3, 0, 0, 0);
    checkOutput("t10_words_done", 32'(words_done), 32'd3);
    checkOutput("t10_word0", mem[320], 32'hA5000008);

    applyStimulus(BASE, BASE + 32'h4, 3, 0, 0, 0);
    checkOutput("t11_overlap1", mem[1], 32'h11111111);
    checkOutput("t11_overlap2", mem[2], 32'h11111111);
    checkOutput("t11_overlap3", mem[3], 32'h11111111);

    checkOutput("out_of_region_writes", 32'(badWrites), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
